// File: rtl/txn_perf_monitor.sv
// Per-channel HLS block-level handshake monitor: transaction count, last/max latency, stall cycles.
// Optional macro TXN_PERF_MAX_LAT_EN compiles in per-channel maximum-latency tracking.
module txn_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [1:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy,
    output logic              frozen
);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    state_t state_q [NUM_CH];
    state_t state_d [NUM_CH];
    cnt_t   lat_q   [NUM_CH];
    cnt_t   lat_d   [NUM_CH];
    cnt_t   txn_q   [NUM_CH];
    cnt_t   txn_d   [NUM_CH];
    cnt_t   last_q  [NUM_CH];
    cnt_t   last_d  [NUM_CH];
    cnt_t   stall_q [NUM_CH];
    cnt_t   stall_d [NUM_CH];
`ifdef TXN_PERF_MAX_LAT_EN
    cnt_t   max_q   [NUM_CH];
    cnt_t   max_d   [NUM_CH];
`endif
    logic   cmpl     [NUM_CH];
    cnt_t   cmpl_lat [NUM_CH];

    logic   frozen_q;
    logic   hold_all;
    cnt_t   rd_mux;
    logic   vld_p1;
    cnt_t   rd_data_p1;
    logic   unused_ready;

    assign unused_ready = ^ap_ready;
    // finish sampled at an edge already blocks that edge's updates
    assign hold_all = frozen_q | finish;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            lat_d[c]    = lat_q[c];
            txn_d[c]    = txn_q[c];
            last_d[c]   = last_q[c];
            stall_d[c]  = stall_q[c];
`ifdef TXN_PERF_MAX_LAT_EN
            max_d[c]    = max_q[c];
`endif
            cmpl[c]     = 1'b0;
            cmpl_lat[c] = '0;
            if (!hold_all) begin
                case (state_q[c])
                    IDLE: begin
                        if (ap_start[c]) begin
                            if (ap_done[c]) begin
                                cmpl[c]     = 1'b1;
                                cmpl_lat[c] = cnt_t'(1);
                            end else begin
                                state_d[c] = ACTIVE;
                                lat_d[c]   = cnt_t'(1);
                            end
                        end
                    end
                    ACTIVE: begin
                        if (ap_done[c]) begin
                            cmpl[c]     = 1'b1;
                            cmpl_lat[c] = sat_inc(lat_q[c]);
                        end else begin
                            lat_d[c] = sat_inc(lat_q[c]);
                        end
                    end
                    HOLD: begin
                        if (ap_continue[c]) state_d[c] = IDLE;
                        else                stall_d[c] = sat_inc(stall_q[c]);
                    end
                    default: state_d[c] = IDLE;
                endcase
                if (cmpl[c]) begin
                    txn_d[c]   = sat_inc(txn_q[c]);
                    last_d[c]  = cmpl_lat[c];
                    lat_d[c]   = '0;
                    state_d[c] = ap_continue[c] ? IDLE : HOLD;
`ifdef TXN_PERF_MAX_LAT_EN
                    if (cmpl_lat[c] > max_q[c]) max_d[c] = cmpl_lat[c];
`endif
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (int'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                2'd0:    rd_mux = txn_q[rd_ch];
                2'd1:    rd_mux = last_q[rd_ch];
`ifdef TXN_PERF_MAX_LAT_EN
                2'd2:    rd_mux = max_q[rd_ch];
`endif
                2'd3:    rd_mux = stall_q[rd_ch];
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            frozen_q   <= 1'b0;
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= IDLE;
                lat_q[c]   <= '0;
                txn_q[c]   <= '0;
                last_q[c]  <= '0;
                stall_q[c] <= '0;
`ifdef TXN_PERF_MAX_LAT_EN
                max_q[c]   <= '0;
`endif
            end
        end else begin
            frozen_q <= hold_all;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                lat_q[c]   <= lat_d[c];
                txn_q[c]   <= txn_d[c];
                last_q[c]  <= last_d[c];
                stall_q[c] <= stall_d[c];
`ifdef TXN_PERF_MAX_LAT_EN
                max_q[c]   <= max_d[c];
`endif
            end
            // read stage: captures pre-update counter values
            vld_p1 <= rd_req;
            if (rd_req) rd_data_p1 <= rd_mux;
        end
    end

    always_comb begin
        busy = '0;
        for (int c = 0; c < NUM_CH; c++) busy[c] = (state_q[c] != IDLE);
    end

    assign frozen   = frozen_q;
    assign rd_valid = vld_p1;
    assign rd_data  = rd_data_p1;

endmodule

// File: tb/tb_txn_perf_monitor.sv
// Self-checking bench for txn_perf_monitor: vector table, directed corner sequences, random traffic vs. model.
module tb_txn_perf_monitor;
    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 3;
    localparam int MAXV   = 255;
`ifdef TXN_PERF_MAX_LAT_EN
    localparam bit MAXEN = 1'b1;
`else
    localparam bit MAXEN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              finish;
    logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
    logic              rd_req;
    logic [CH_W-1:0]   rd_ch;
    logic [1:0]        rd_sel;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] busy;
    logic              frozen;

    txn_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .frozen(frozen)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: transactions timestamped by cycle number
    int   cyc = 0;
    bit   m_act   [NUM_CH];
    bit   m_hold  [NUM_CH];
    int   m_start [NUM_CH];
    int   m_txn   [NUM_CH];
    int   m_last  [NUM_CH];
    int   m_max   [NUM_CH];
    int   m_stall [NUM_CH];
    bit   m_frozen = 1'b0;
    logic [CNT_W-1:0] exp_rd = '0;

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic logic [CNT_W-1:0] mread(input int ch, input int sel);
        if (ch >= NUM_CH) return '0;
        case (sel)
            0:       return CNT_W'(m_txn[ch]);
            1:       return CNT_W'(m_last[ch]);
            2:       return MAXEN ? CNT_W'(m_max[ch]) : '0;
            default: return CNT_W'(m_stall[ch]);
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] mbusy();
        logic [NUM_CH-1:0] b;
        for (int c = 0; c < NUM_CH; c++) b[c] = m_act[c] | m_hold[c];
        return b;
    endfunction

    function automatic void model_edge();
        int lat;
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_act[c] = 0; m_hold[c] = 0; m_txn[c] = 0;
                m_last[c] = 0; m_max[c] = 0; m_stall[c] = 0;
            end
            m_frozen = 0;
        end else if (m_frozen || finish) begin
            m_frozen = 1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_hold[c]) begin
                    if (ap_continue[c]) m_hold[c] = 0;
                    else m_stall[c] = sat(m_stall[c] + 1);
                end else if (m_act[c] || ap_start[c]) begin
                    if (!m_act[c]) m_start[c] = cyc;
                    if (ap_done[c]) begin
                        lat = sat(cyc - m_start[c] + 1);
                        m_txn[c]  = sat(m_txn[c] + 1);
                        m_last[c] = lat;
                        if (lat > m_max[c]) m_max[c] = lat;
                        m_act[c]  = 0;
                        m_hold[c] = !ap_continue[c];
                    end else begin
                        m_act[c] = 1;
                    end
                end
            end
        end
        cyc++;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: predict, apply edge, compare every output
    task automatic step();
        bit exp_vld;
        exp_vld = reset && rd_req;
        if (!reset) exp_rd = '0;
        else if (rd_req) exp_rd = mread(int'(rd_ch), int'(rd_sel));
        model_edge();
        @(posedge clock);
        #1;
        chk("rd_valid", rd_valid, exp_vld);
        chk("rd_data", rd_data, exp_rd);
        chk("busy", busy, mbusy());
        chk("frozen", frozen, m_frozen);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        ap_start = '0; ap_done = '0; ap_continue = '1; ap_ready = '0;
        finish = 0; rd_req = 0; rd_ch = '0; rd_sel = '0;
    endtask

    task automatic rd(input int ch, input int sel, output logic [CNT_W-1:0] val);
        logic [CH_W-1:0] chv;
        chv = CH_W'(ch);
        rd_req = 1; rd_ch = chv; rd_sel = 2'(sel);
        step();
        val = rd_data;
        rd_req = 0;
    endtask

    task automatic run_txn(input int ch, input int lat, input int stl);
        for (int i = 0; i < lat; i++) begin
            ap_start = '0; ap_done = '0; ap_continue = '1;
            ap_start[ch]    = (i == 0);
            ap_done[ch]     = (i == lat - 1);
            ap_continue[ch] = !((i == lat - 1) && (stl > 0));
            step();
        end
        for (int s = 0; s < stl; s++) begin
            ap_start = '0; ap_done = '0; ap_continue = '1;
            ap_continue[ch] = 0;
            step();
        end
        ap_start = '0; ap_done = '0; ap_continue = '1;
        if (stl > 0) step();
    endtask

    typedef struct {
        int ch; int lat; int stl;
        int exp_txn; int exp_last; int exp_max; int exp_stall;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [CNT_W-1:0] v;
        int t3;

        vecs[0] = '{0, 5, 0, 1, 5, 5, 0};
        vecs[1] = '{1, 1, 0, 1, 1, 1, 0};
        vecs[2] = '{1, 3, 0, 2, 3, 3, 0};
        vecs[3] = '{2, 2, 7, 1, 2, 2, 7};
        vecs[4] = '{1, 2, 0, 3, 2, 3, 0};
        vecs[5] = '{4, 4, 3, 1, 4, 4, 3};

        idle_inputs();
        reset = 0;
        step();
        step();
        reset = 1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].ch, vecs[i].lat, vecs[i].stl);
            rd(vecs[i].ch, 0, v); chk($sformatf("vec%0d_txn", i), v, vecs[i].exp_txn);
            rd(vecs[i].ch, 1, v); chk($sformatf("vec%0d_last", i), v, vecs[i].exp_last);
            rd(vecs[i].ch, 2, v); chk($sformatf("vec%0d_max", i), v, MAXEN ? vecs[i].exp_max : 0);
            rd(vecs[i].ch, 3, v); chk($sformatf("vec%0d_stall", i), v, vecs[i].exp_stall);
        end

        // read coincident with done returns the old count
        ap_start[0] = 1; step();
        ap_start[0] = 0; ap_done[0] = 1;
        rd(0, 0, v); chk("coincident_old", v, 1);
        ap_done[0] = 0;
        rd(0, 0, v); chk("coincident_new", v, 2);

        // out-of-range channels
        rd(NUM_CH, 0, v); chk("oob_ch5", v, 0);
        rd(7, 3, v); chk("oob_ch7", v, 0);

        // latency and count saturation
        run_txn(3, 300, 0);
        rd(3, 1, v); chk("lat_sat", v, 255);
        for (int i = 0; i < 300; i++) run_txn(3, 1, 0);
        rd(3, 0, v); chk("txn_sat", v, 255);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            ap_start    = NUM_CH'($urandom) & NUM_CH'($urandom);
            ap_done     = NUM_CH'($urandom) & NUM_CH'($urandom);
            ap_continue = NUM_CH'($urandom) | NUM_CH'($urandom);
            ap_ready    = NUM_CH'($urandom);
            rd_req      = 1'($urandom);
            rd_ch       = CH_W'($urandom_range(0, 7));
            rd_sel      = 2'($urandom);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) step();

        // freeze mid-transaction on ch3; done with finish is not counted
        t3 = m_txn[3];
        ap_start[3] = 1; step();
        ap_start[3] = 0; step();
        finish = 1; ap_done[3] = 1; step();
        finish = 0; ap_done[3] = 0;
        rd(3, 0, v); chk("freeze_txn", v, t3);
        chk("freeze_flag", frozen, 1);
        for (int i = 0; i < 20; i++) begin
            ap_start = NUM_CH'($urandom); ap_done = NUM_CH'($urandom);
            ap_continue = NUM_CH'($urandom);
            rd_req = 1; rd_ch = CH_W'($urandom_range(0, NUM_CH - 1)); rd_sel = 2'($urandom);
            step();
        end
        idle_inputs();
        rd(3, 0, v); chk("freeze_hold", v, t3);

        // reset during ACTIVE discards everything
        reset = 0; step(); reset = 1; step();
        ap_start[0] = 1; step();
        ap_start[0] = 0; step(); step();
        reset = 0; step(); reset = 1;
        for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < 4; s++) begin
                rd(c, s, v); chk($sformatf("post_reset_c%0d_s%0d", c, s), v, 0);
            end
        chk("post_reset_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
